// File: rtl/jk_pkg.sv
// Shared JK decode/next-state helpers for the JK flip-flop bank.
package jk_pkg;

  typedef enum logic [1:0] {JK_HOLD, JK_RESET, JK_SET, JK_TOGGLE} jk_op_e;

  function automatic jk_op_e jk_decode(input logic j, input logic k);
    case ({j, k})
      2'b01:   return JK_RESET;
      2'b10:   return JK_SET;
      2'b11:   return JK_TOGGLE;
      default: return JK_HOLD;
    endcase
  endfunction

  function automatic logic jk_next(input logic q, input jk_op_e op);
    case (op)
      JK_RESET:  return 1'b0;
      JK_SET:    return 1'b1;
      JK_TOGGLE: return ~q;
      default:   return q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK bit: sync active-low reset, then clear > preset > JK rule.
// JK_FLIP_FLOP_CE_EN adds a clock enable gating everything but reset.
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
`ifdef JK_FLIP_FLOP_CE_EN
  input  logic ce,
`endif
  input  logic j,
  input  logic k,
  input  logic preset,
  input  logic clear,
  output logic q
);

  logic en;
`ifdef JK_FLIP_FLOP_CE_EN
  assign en = ce;
`else
  assign en = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n)    q <= RESET_VAL;
    else if (en) begin
      if (clear)       q <= 1'b0;
      else if (preset) q <= 1'b1;
      else             q <= jk_next(q, jk_decode(j, k));
    end
  end

endmodule

// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent JK flip-flops; q_n is derived from q, not stored.
// Optional clock enable port when JK_FLIP_FLOP_CE_EN is defined.
module jk_flip_flop
  import jk_pkg::*;
#(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
`ifdef JK_FLIP_FLOP_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] preset,
  input  logic [WIDTH-1:0] clear,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_cell #(.RESET_VAL(RESET_VAL[g])) u_cell (
      .clock   (clock),
      .reset_n (reset_n),
`ifdef JK_FLIP_FLOP_CE_EN
      .ce      (ce),
`endif
      .j       (j[g]),
      .k       (k[g]),
      .preset  (preset[g]),
      .clear   (clear[g]),
      .q       (q[g])
    );
  end

  assign q_n = ~q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Scoreboard bench: expected q pushed when stimulus is driven, popped after the edge.
module tb_jk_flip_flop;

  localparam logic [3:0] RV4 = 4'b1010;

  logic       clock = 1'b0;
  logic       rst4_n, rst1_n;
  logic [3:0] j4, k4, p4, c4, q4, qn4;
  logic [0:0] j1, k1, p1, c1, q1, qn1;
`ifdef JK_FLIP_FLOP_CE_EN
  logic       ce4;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [3:0] exp4_q[$];
  string      tag4_q[$];
  logic       exp1_q[$];
  string      tag1_q[$];

  always #5 clock = ~clock;

  jk_flip_flop #(.WIDTH(4), .RESET_VAL(RV4)) dut4 (
    .clock(clock), .reset_n(rst4_n),
`ifdef JK_FLIP_FLOP_CE_EN
    .ce(ce4),
`endif
    .j(j4), .k(k4), .preset(p4), .clear(c4), .q(q4), .q_n(qn4)
  );

  jk_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .clock(clock), .reset_n(rst1_n),
`ifdef JK_FLIP_FLOP_CE_EN
    .ce(1'b1),
`endif
    .j(j1), .k(k1), .preset(p1), .clear(c1), .q(q1), .q_n(qn1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // independent reference: truth-table lookup per bit
  function automatic logic [3:0] model4(input logic [3:0] q, input logic rn,
      input logic [3:0] j, input logic [3:0] k, input logic [3:0] p,
      input logic [3:0] c, input logic ce);
    logic [3:0] r;
    if (!rn) return RV4;
    if (!ce) return q;
    for (int i = 0; i < 4; i++) begin
      if (c[i])                   r[i] = 1'b0;
      else if (p[i])              r[i] = 1'b1;
      else if (j[i] && k[i])      r[i] = !q[i];
      else if (j[i])              r[i] = 1'b1;
      else if (k[i])              r[i] = 1'b0;
      else                        r[i] = q[i];
    end
    return r;
  endfunction

  task automatic step4(input string tag, input logic rn, input logic [3:0] j,
      input logic [3:0] k, input logic [3:0] p, input logic [3:0] c,
      input logic ce, input logic [3:0] exp);
    logic [3:0] e;
    string t;
    rst4_n = rn; j4 = j; k4 = k; p4 = p; c4 = c;
`ifdef JK_FLIP_FLOP_CE_EN
    ce4 = ce;
`endif
    exp4_q.push_back(exp);
    tag4_q.push_back(tag);
    @(posedge clock); #1;
    e = exp4_q.pop_front();
    t = tag4_q.pop_front();
    chk(t, {28'd0, q4}, {28'd0, e});
    chk({t, "_qn"}, {28'd0, qn4}, {28'd0, ~e});
  endtask

  task automatic step1(input string tag, input logic rn, input logic j,
      input logic k, input logic p, input logic c, input logic exp);
    logic e;
    string t;
    rst1_n = rn; j1 = j; k1 = k; p1 = p; c1 = c;
    exp1_q.push_back(exp);
    tag1_q.push_back(tag);
    @(posedge clock); #1;
    e = exp1_q.pop_front();
    t = tag1_q.pop_front();
    chk(t, {31'd0, q1}, {31'd0, e});
    chk({t, "_qn"}, {31'd0, qn1}, {31'd0, ~e});
  endtask

  initial begin
    logic [3:0] m, rj, rk, rp, rc;
    logic       rr;
    rst4_n = 0; j4 = '0; k4 = '0; p4 = '0; c4 = '0;
    rst1_n = 0; j1 = '0; k1 = '0; p1 = '0; c1 = '0;
`ifdef JK_FLIP_FLOP_CE_EN
    ce4 = 1'b1;
`endif
    #1;
    // reset with toggling inputs, then release
    step4("rst_a", 0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'b1010);
    step4("rst_b", 0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'b1010);
    step4("rel_tog", 1, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'b0101);
    step4("tog2", 1, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'b1010);
    // truth table from zero
    step4("clr_all", 1, 4'h0, 4'h0, 4'h0, 4'hF, 1, 4'b0000);
    step4("jk_1", 1, 4'b1010, 4'b0110, 4'h0, 4'h0, 1, 4'b1010);
    step4("jk_2", 1, 4'b1010, 4'b0110, 4'h0, 4'h0, 1, 4'b1000);
    step4("hold", 1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'b1000);
    // preset / clear priority
    step4("clr_0", 1, 4'h0, 4'h0, 4'h0, 4'hF, 1, 4'b0000);
    step4("pre_over_k", 1, 4'h0, 4'hF, 4'hF, 4'h0, 1, 4'b1111);
    step4("clr_over_pre", 1, 4'h0, 4'hF, 4'hF, 4'hF, 1, 4'b0000);
    step4("rst_over_pre", 0, 4'h0, 4'hF, 4'hF, 4'h0, 1, RV4);
    step4("mixed_bits", 1, 4'b0011, 4'b0101, 4'b0100, 4'b1000, 1, 4'b0111);
`ifdef JK_FLIP_FLOP_CE_EN
    step4("ce0_a", 1, 4'hF, 4'hF, 4'hF, 4'h0, 0, 4'b0111);
    step4("ce0_b", 1, 4'hF, 4'hF, 4'hF, 4'h0, 0, 4'b0111);
    step4("ce0_c", 1, 4'hF, 4'hF, 4'hF, 4'h0, 0, 4'b0111);
    step4("ce0_clr", 1, 4'h0, 4'h0, 4'h0, 4'hF, 0, 4'b0111);
    step4("ce0_rst", 0, 4'hF, 4'hF, 4'hF, 4'h0, 0, RV4);
    step4("ce1_tog", 1, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'b0101);
    m = 4'b0101;
`else
    m = 4'b0111;
`endif
    // random traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      rr = ($urandom_range(0, 9) != 0);
      rj = 4'($urandom); rk = 4'($urandom);
      rp = 4'($urandom) & 4'($urandom);
      rc = 4'($urandom) & 4'($urandom);
`ifdef JK_FLIP_FLOP_CE_EN
      begin
        logic rce;
        rce = ($urandom_range(0, 3) != 0);
        m = model4(m, rr, rj, rk, rp, rc, rce);
        step4("rand", rr, rj, rk, rp, rc, rce, m);
      end
`else
      m = model4(m, rr, rj, rk, rp, rc, 1'b1);
      step4("rand", rr, rj, rk, rp, rc, 1'b1, m);
`endif
    end
    // width-1 divider
    step1("d_rst", 0, 1, 1, 0, 0, 0);
    for (int n = 0; n < 8; n++)
      step1("div2", 1, 1, 1, 0, 0, (n % 2 == 0) ? 1'b1 : 1'b0);
    step1("div2_hi", 1, 1, 1, 0, 0, 1);
    step1("mid_rst", 0, 1, 1, 0, 0, 0);
    step1("resume", 1, 1, 1, 0, 0, 1);
    step1("resume2", 1, 1, 1, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/jk_flip_flop.md
Name: jk_flip_flop

Overview:
- Parameterised bank of WIDTH independent JK flip-flops with synchronous clear and preset.
- Used as the basic storage/toggle cell of the frequency-divider chains. With J=K=1 and preset/clear tied low, each bit toggles every active clock edge, which is divide-by-2.
- All state changes occur on the rising edge of the single clock.

Parameters:
- WIDTH, 1, number of independent JK bits in the bank.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q when reset_n is sampled low.

Ports:
- clock  input  1  single rising-edge clock.
- reset_n  input  1  synchronous, active-low reset; loads RESET_VAL.
- j  input  WIDTH  per-bit J input.
- k  input  WIDTH  per-bit K input.
- preset  input  WIDTH  per-bit synchronous preset, active-high; forces bit to 1.
- clear  input  WIDTH  per-bit synchronous clear, active-high; forces bit to 0.
- q  output  WIDTH  registered state.
- q_n  output  WIDTH  bitwise inverse of q (combinational from q, never a separate register).

Behaviour:
- One clock domain; reset is synchronous and active-low. Nothing changes except on the rising edge of clock.
- Priority per bit at each rising edge, highest first: reset_n==0 -> RESET_VAL bit; clear==1 -> 0; preset==1 -> 1; otherwise the JK rule.
- JK rule: J=0,K=0 hold; J=0,K=1 -> 0; J=1,K=0 -> 1; J=1,K=1 -> toggle (~q).
- clear and preset both high on the same bit: clear wins, bit becomes 0.
- Latency: q reflects inputs sampled at edge n immediately after edge n (1 cycle). q_n is always ~q, with no extra latency.
- Reset mid-operation: a toggle in progress is discarded; q = RESET_VAL after the edge where reset_n is low. The JK rule resumes on the first edge with reset_n high.
- Bits are fully independent; no carry or interaction between bits.
- Power-up before the first reset is undefined in RTL. Benches must apply reset_n low for at least 1 edge.
- Divide-by-2 usage: J=K=1, preset=clear=0 -> q period = 2 clock periods, 50 % duty.

Optional Feature:
- Macro: JK_FLIP_FLOP_CE_EN.
- Defined: adds input port ce (1 bit). When ce==0 at an edge, the JK rule and preset/clear are suppressed and q holds. reset_n still acts regardless of ce.
- Undefined: no ce port; behaviour is identical to ce permanently 1.

Decomposition:
- Shared package jk_pkg:
  - enum jk_op_e {JK_HOLD, JK_RESET, JK_SET, JK_TOGGLE}.
  - Pure function jk_decode(j,k) -> jk_op_e.
  - Pure function jk_next(q, op) -> next bit.
- Sub-module jk_cell: one bit holding clock, reset_n, j, k, preset, clear, (ce), q, with RESET_VAL bit as a parameter. Instantiated WIDTH times via generate. q_n is formed at the top level.

Test Plan:
- Reset: WIDTH=4, RESET_VAL=4'b1010, reset_n=0 for 2 edges with j=k=4'hF -> q=4'b1010, q_n=4'b0101; after release with j=k=4'hF, next edge -> q=4'b0101.
- JK truth table: WIDTH=4, q=0 after reset, j=4'b1010, k=4'b0110 (bits: 3=set, 2=reset, 1=toggle, 0=hold) -> q=4'b1010; repeat the same inputs -> q=4'b1000.
- Divide-by-2: WIDTH=1, j=k=1, preset=clear=0 for 8 edges -> q sequence 1,0,1,0,1,0,1,0 (period 2 clocks).
- Preset/clear priority: q=0, preset=1, clear=0, j=0, k=1 -> q=1; then preset=1, clear=1 -> q=0; then reset_n=0 with preset=1 -> q=RESET_VAL.
- Reset mid-toggle: j=k=1 running, assert reset_n=0 for exactly 1 edge when q=1 -> q=RESET_VAL (0) at that edge, toggles to 1 on the next edge.
- With JK_FLIP_FLOP_CE_EN defined: ce=0, j=k=1, preset=1 for 3 edges -> q unchanged; ce=0 with reset_n=0 -> q=RESET_VAL.
